// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: tracks in-flight writers after EX and derives
// EX operand forward selects, load-use stall and multi-cycle busy stall.
module fwd_hazard_unit #(
  parameter  int NUM_SRC    = 2,
  parameter  int NUM_STAGES = 2,
  parameter  int LOAD_LAT   = 1,
  parameter  int AW         = 5,
  parameter  int CW         = 4,
  localparam int SW         = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  ex_wr_valid,
  input  logic [AW-1:0]         ex_rd_addr,
  input  logic                  ex_is_load,
  input  logic [NUM_SRC*AW-1:0] ex_rs_addr,
  input  logic [NUM_SRC*AW-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]    id_rs_used,
  input  logic                  ex_mc_start,
  input  logic [CW-1:0]         ex_mc_len,
  output logic [NUM_SRC*SW-1:0] fwd_sel,
  output logic                  load_use_stall,
  output logic                  mc_stall,
  output logic                  stall
);

  logic [NUM_STAGES:1] r_vld;
  logic [NUM_STAGES:1] r_ld;
  logic [AW-1:0]       r_rd [1:NUM_STAGES];
  logic [CW-1:0]       r_mc_cnt;

  logic                w_cap_vld;
  logic [NUM_STAGES:0] w_pv;
  logic [NUM_STAGES:0] w_pld;
  logic [AW-1:0]       w_prd [0:NUM_STAGES];
  logic [NUM_SRC-1:0]  w_lu;

  assign w_cap_vld = ex_wr_valid && (ex_rd_addr != '0);
  assign mc_stall  = (r_mc_cnt != '0);
  assign stall     = load_use_stall | mc_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (!hold) begin
      r_vld[1] <= w_cap_vld && !mc_stall;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  // Payload needs no reset; it is qualified by r_vld.
  always_ff @(posedge clk) begin
    if (!hold) begin
      r_rd[1] <= ex_rd_addr;
      r_ld[1] <= ex_is_load;
      for (int k = 2; k <= NUM_STAGES; k++) begin
        r_rd[k] <= r_rd[k-1];
        r_ld[k] <= r_ld[k-1];
      end
    end
  end

  // Counter runs even under hold: the unit's occupancy is wall-clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mc_cnt <= '0;
    end else if (ex_mc_start && (r_mc_cnt == '0)) begin
      r_mc_cnt <= ex_mc_len;
    end else if (r_mc_cnt != '0) begin
      r_mc_cnt <= r_mc_cnt - 1'b1;
    end
  end

  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_STAGES; k >= 1; k--) begin
        if (r_vld[k] && (r_rd[k] == ex_rs_addr[i*AW +: AW])
            && (ex_rs_addr[i*AW +: AW] != '0)) begin
          fwd_sel[i*SW +: SW] = SW'(k);
        end
      end
    end
  end

  assign w_pv  = {r_vld, w_cap_vld};
  assign w_pld = {r_ld, ex_is_load};

  always_comb begin
    w_prd[0] = ex_rd_addr;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      w_prd[k] = r_rd[k];
    end
  end

  // Youngest matching producer decides; an older load can be shadowed.
  always_comb begin
    logic hit;
    logic is_ld;
    int   pos;
    w_lu = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit   = 1'b0;
      is_ld = 1'b0;
      pos   = 0;
      for (int p = NUM_STAGES; p >= 0; p--) begin
        if (w_pv[p] && (w_prd[p] == id_rs_addr[i*AW +: AW])
            && (id_rs_addr[i*AW +: AW] != '0)) begin
          hit   = 1'b1;
          is_ld = w_pld[p];
          pos   = p;
        end
      end
      w_lu[i] = id_rs_used[i] && hit && is_ld && (pos < LOAD_LAT);
    end
  end

  assign load_use_stall = |w_lu;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default and 3-stage/2-latency instances
// against a queue-based reference model, directed then random.
module tb_fwd_hazard_unit;

  typedef struct packed {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } ent_t;

  logic       clk = 0;
  logic       rst;
  logic       hold;
  logic       ex_wr_valid;
  logic [4:0] ex_rd_addr;
  logic       ex_is_load;
  logic [9:0] ex_rs_addr;
  logic [9:0] id_rs_addr;
  logic [1:0] id_rs_used;
  logic       ex_mc_start;
  logic [3:0] ex_mc_len;

  logic [3:0] fwd_a, fwd_b;
  logic       lu_a, mc_a, st_a;
  logic       lu_b, mc_b, st_b;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int mc_last = -1;
  ent_t qa[$];
  ent_t qb[$];

  always #5 clk = ~clk;

  fwd_hazard_unit dut_a (
    .clk(clk), .rst(rst), .hold(hold),
    .ex_wr_valid(ex_wr_valid), .ex_rd_addr(ex_rd_addr),
    .ex_is_load(ex_is_load), .ex_rs_addr(ex_rs_addr),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len),
    .fwd_sel(fwd_a), .load_use_stall(lu_a),
    .mc_stall(mc_a), .stall(st_a)
  );

  fwd_hazard_unit #(.NUM_STAGES(3), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .hold(hold),
    .ex_wr_valid(ex_wr_valid), .ex_rd_addr(ex_rd_addr),
    .ex_is_load(ex_is_load), .ex_rs_addr(ex_rs_addr),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len),
    .fwd_sel(fwd_b), .load_use_stall(lu_b),
    .mc_stall(mc_b), .stall(st_b)
  );

  function automatic int exp_fwd(input ent_t q[$], input bit [4:0] rs);
    if (rs == 0) return 0;
    foreach (q[k]) if (q[k].v && q[k].rd == rs) return k + 1;
    return 0;
  endfunction

  function automatic bit exp_lu(input ent_t q[$], input int lat,
                                input bit [4:0] rs, input bit used);
    ent_t pos[$];
    if (!used || rs == 0) return 0;
    pos.push_back('{ex_wr_valid && ex_rd_addr != 0, ex_rd_addr, ex_is_load});
    foreach (q[k]) pos.push_back(q[k]);
    foreach (pos[p]) begin
      if (pos[p].v && pos[p].rd == rs) return pos[p].ld && (p < lat);
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_all();
    bit la, lb, m;
    la = 0;
    lb = 0;
    m  = (cyc <= mc_last);
    for (int i = 0; i < 2; i++) begin
      chk("fwdA", 32'(fwd_a[i*2 +: 2]), exp_fwd(qa, ex_rs_addr[i*5 +: 5]));
      chk("fwdB", 32'(fwd_b[i*2 +: 2]), exp_fwd(qb, ex_rs_addr[i*5 +: 5]));
      la |= exp_lu(qa, 1, id_rs_addr[i*5 +: 5], id_rs_used[i]);
      lb |= exp_lu(qb, 2, id_rs_addr[i*5 +: 5], id_rs_used[i]);
    end
    chk("luA", 32'(lu_a), 32'(la));
    chk("luB", 32'(lu_b), 32'(lb));
    chk("mcA", 32'(mc_a), 32'(m));
    chk("mcB", 32'(mc_b), 32'(m));
    chk("stA", 32'(st_a), 32'(la | m));
    chk("stB", 32'(st_b), 32'(lb | m));
  endtask

  task automatic model_edge();
    bit m;
    ent_t e;
    m = (cyc <= mc_last);
    if (rst) begin
      foreach (qa[k]) qa[k] = '0;
      foreach (qb[k]) qb[k] = '0;
      mc_last = cyc;
    end else begin
      if (!hold) begin
        e = '{ex_wr_valid && ex_rd_addr != 0 && !m, ex_rd_addr, ex_is_load};
        qa.push_front(e);
        void'(qa.pop_back());
        qb.push_front(e);
        void'(qb.pop_back());
      end
      if (ex_mc_start && !m) mc_last = cyc + int'(ex_mc_len);
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    chk_all();
  endtask

  task automatic idle();
    rst = 0; hold = 0; ex_wr_valid = 0; ex_rd_addr = 0;
    ex_is_load = 0; ex_rs_addr = 0; id_rs_addr = 0;
    id_rs_used = 0; ex_mc_start = 0; ex_mc_len = 0;
  endtask

  initial begin
    repeat (2) qa.push_back('0);
    repeat (3) qb.push_back('0);
    idle();
    rst = 1;
    step();
    rst = 0;
    settle();
    chk("rst_fwdA", 32'(fwd_a), 0);
    chk("rst_stA", 32'(st_a), 0);
    chk("rst_stB", 32'(st_b), 0);

    // ALU producer x5 followed by consumers
    ex_wr_valid = 1; ex_rd_addr = 5;
    settle(); step();
    ex_wr_valid = 0; ex_rs_addr = 10'(5);
    settle(); chk("x5_s1", 32'(fwd_a[1:0]), 1);
    step();
    settle(); chk("x5_s2", 32'(fwd_a[1:0]), 2);
    step();
    settle(); chk("x5_goneA", 32'(fwd_a[1:0]), 0);
    chk("x5_s3B", 32'(fwd_b[1:0]), 3);

    // two writers to x7, then a write to x0
    idle(); ex_wr_valid = 1; ex_rd_addr = 7;
    settle(); step();
    settle(); step();
    ex_wr_valid = 0; ex_rs_addr = {5'd7, 5'd7};
    settle(); chk("x7_both", 32'(fwd_a), 32'h5);
    ex_wr_valid = 1; ex_rd_addr = 0; ex_rs_addr = 0;
    settle(); step();
    ex_wr_valid = 0;
    settle(); chk("x0_none", 32'(fwd_a), 0);

    // load x3 with ID consumer; first without use
    idle(); ex_wr_valid = 1; ex_rd_addr = 3; ex_is_load = 1;
    id_rs_addr = 10'(3);
    settle(); chk("ld_unused", 32'(st_a | st_b), 0);
    id_rs_used = 2'b01;
    settle(); chk("ld_luA0", 32'(lu_a), 1);
    chk("ld_luB0", 32'(lu_b), 1);
    step();
    ex_wr_valid = 0; ex_is_load = 0; ex_rs_addr = 10'(3);
    settle(); chk("ld_luA1", 32'(lu_a), 0);
    chk("ld_fwdA", 32'(fwd_a[1:0]), 1);
    chk("ld_luB1", 32'(lu_b), 1);
    step();
    settle(); chk("ld_luB2", 32'(lu_b), 0);
    chk("ld_fwdB", 32'(fwd_b[1:0]), 2);

    // multi-cycle op, len 3, restart ignored, capture suppressed
    idle(); ex_mc_start = 1; ex_mc_len = 3;
    settle(); chk("mc_pre", 32'(mc_a), 0);
    step();
    ex_mc_start = 0; ex_wr_valid = 1; ex_rd_addr = 9;
    settle(); chk("mc_c1", 32'(mc_a), 1);
    step();
    ex_wr_valid = 0; ex_mc_start = 1; ex_mc_len = 7; ex_rs_addr = 10'(9);
    settle(); chk("mc_c2", 32'(mc_a), 1);
    chk("mc_nocap", 32'(fwd_a[1:0]), 0);
    step();
    ex_mc_start = 0;
    settle(); chk("mc_c3", 32'(mc_a), 1);
    step();
    settle(); chk("mc_end", 32'(mc_a), 0);
    ex_mc_start = 1; ex_mc_len = 0;
    step();
    ex_mc_start = 0;
    settle(); chk("mc_len0", 32'(mc_a), 0);

    // hold freezes slot 1 holding x9
    idle(); ex_wr_valid = 1; ex_rd_addr = 9;
    settle(); step();
    ex_wr_valid = 0; hold = 1; ex_rs_addr = 10'(9);
    settle(); chk("hold_0", 32'(fwd_a[1:0]), 1);
    step();
    settle(); chk("hold_1", 32'(fwd_a[1:0]), 1);
    step();
    hold = 0;
    settle(); chk("hold_rel", 32'(fwd_a[1:0]), 1);
    step();
    settle(); chk("hold_adv", 32'(fwd_a[1:0]), 2);

    // reset mid-operation
    idle(); ex_mc_start = 1; ex_mc_len = 5; ex_wr_valid = 1; ex_rd_addr = 4;
    settle(); step();
    ex_mc_start = 0;
    settle(); step();
    rst = 1;
    step();
    rst = 0; ex_wr_valid = 0; ex_rs_addr = {5'd4, 5'd4};
    id_rs_addr = {5'd4, 5'd4}; id_rs_used = 2'b11;
    settle(); chk("rst2_fwd", 32'(fwd_a), 0);
    chk("rst2_st", 32'(st_a), 0);
    chk("rst2_mc", 32'(mc_b), 0);

    // random traffic over a small register pool
    for (int n = 0; n < 800; n++) begin
      rst         = ($urandom_range(0, 79) == 0);
      hold        = ($urandom_range(0, 4) == 0);
      ex_wr_valid = $urandom_range(0, 1);
      ex_rd_addr  = 5'($urandom_range(0, 4));
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_rs_addr  = {5'($urandom_range(0, 4)), 5'($urandom_range(0, 4))};
      id_rs_addr  = {5'($urandom_range(0, 4)), 5'($urandom_range(0, 4))};
      id_rs_used  = 2'($urandom_range(0, 3));
      ex_mc_start = ($urandom_range(0, 11) == 0);
      ex_mc_len   = 4'($urandom_range(0, 5));
      settle();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
